reg_bank: RTL



---
 rtl/reg_bank.sv | 93 +++++++++
 1 files changed

// File: rtl/reg_bank.sv
// reg_bank: NREGS x WIDTH general registers (one doubles as PC with
// incrementer) plus an IR_WIDTH instruction register, for the multicycle
// datapath.
// Ports:
//   Clock, Reset (sync, active-high)
//   BusIn/Rin      - one-hot (or broadcast) load from the shared bus
//   IncrPC         - PC register += 1 (a load of the PC register wins)
//   IRin/IRdata    - instruction register load
//   Rout           - one-hot read select; BusOut/RoutErr are combinational
//   PC, IR         - current PC register and IR contents
module reg_bank #(
    parameter int                 WIDTH    = 16,
    parameter int                 NREGS    = 8,
    parameter int                 PC_INDEX = NREGS - 1,
    parameter int                 IR_WIDTH = 9,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [WIDTH-1:0]      BusIn,
    input  logic [NREGS-1:0]      Rin,
    input  logic                  IncrPC,
    input  logic                  IRin,
    input  logic [IR_WIDTH-1:0]   IRdata,
    input  logic [NREGS-1:0]      Rout,
    output logic [WIDTH-1:0]      BusOut,
    output logic                  RoutErr,
    output logic [WIDTH-1:0]      PC,
    output logic [IR_WIDTH-1:0]   IR
);

    if (PC_INDEX < 0 || PC_INDEX >= NREGS) begin : g_bad_pc_index
        $error("reg_bank: PC_INDEX must be below NREGS");
    end
    if (NREGS < 2 || NREGS > 16) begin : g_bad_nregs
        $error("reg_bank: NREGS must be in 2..16");
    end

    localparam logic [NREGS-1:0] ROUT_ONE = NREGS'(1);

    logic [WIDTH-1:0]    regs_q [NREGS];
    logic [WIDTH-1:0]    regs_d [NREGS];
    logic [IR_WIDTH-1:0] ir_q;
    logic [IR_WIDTH-1:0] ir_d;
    logic [WIDTH-1:0]    bus_sel;
    logic                rout_multi;

    // Next state: a bus load beats the PC increment.
    always_comb begin
        regs_d = regs_q;
        ir_d   = ir_q;
        for (int i = 0; i < NREGS; i++) begin
            if (Rin[i]) begin
                regs_d[i] = BusIn;
            end else if (i == PC_INDEX && IncrPC) begin
                regs_d[i] = regs_q[i] + WIDTH'(1);
            end
        end
        if (IRin) begin
            ir_d = IRdata;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == PC_INDEX) ? RESET_PC : '0;
            end
            ir_q <= '0;
        end else begin
            regs_q <= regs_d;
            ir_q   <= ir_d;
        end
    end

    // Read mux: clearing the lowest set bit leaves something only when
    // two or more selects are active; that case drives zero.
    always_comb begin
        bus_sel = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (Rout[i]) begin
                bus_sel = bus_sel | regs_q[i];
            end
        end
        rout_multi = (Rout & (Rout - ROUT_ONE)) != '0;
        BusOut     = rout_multi ? '0 : bus_sel;
        RoutErr    = rout_multi;
    end

    assign PC = regs_q[PC_INDEX];
    assign IR = ir_q;

endmodule
